// File: rtl/dma_reg_master_if.sv
// Register bus between the DMA register master (initiator) and the DMA
// register block (responder): one-cycle valid strobe with read/write select.
interface dma_reg_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr_en;
    logic                  valid;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output addr,
        output wr_en,
        output valid,
        output wdata,
        input  rdata
    );

    modport slave (
        input  addr,
        input  wr_en,
        input  valid,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/dma_reg_master.sv
// DMA register master: on start, writes the four DMA registers back to back,
// optionally reads each one back after RD_LAT cycles and flags mismatches.
module dma_reg_master #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h400,
    parameter int unsigned           RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  verify_en,
    input  logic [DATA_WIDTH-1:0] cfg_intr,
    input  logic [DATA_WIDTH-1:0] cfg_control,
    input  logic [DATA_WIDTH-1:0] cfg_io_addr,
    input  logic [DATA_WIDTH-1:0] cfg_mem_addr,
    dma_reg_master_if.master      bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [3:0]            err_mask
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_REQ,
        RD_WAIT,
        DONE
    } state_t;

    state_t                state;
    logic [1:0]            idx;
    logic [2:0]            lat_cnt;
    logic                  verify;
    logic [DATA_WIDTH-1:0] shadow [4];

    // Register i lives at BASE_ADDR + 4*i; the sum wraps at ADDR_WIDTH bits.
    function automatic logic [ADDR_WIDTH-1:0] reg_addr(input logic [1:0] i);
        return BASE_ADDR + ADDR_WIDTH'({i, 2'b00});
    endfunction

    // Sequencer FSM; every bus and status output is produced here so all are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            lat_cnt   <= '0;
            verify    <= 1'b0;
            bus.addr  <= '0;
            bus.wdata <= '0;
            bus.valid <= 1'b0;
            bus.wr_en <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_mask  <= '0;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            // Strobes default low so each transaction lasts exactly one cycle.
            bus.valid <= 1'b0;
            bus.wr_en <= 1'b0;
            bus.wdata <= '0;
            done      <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        shadow[0] <= cfg_intr;
                        shadow[1] <= cfg_control;
                        shadow[2] <= cfg_io_addr;
                        shadow[3] <= cfg_mem_addr;
                        verify    <= verify_en;
                        err       <= 1'b0;
                        err_mask  <= '0;
                        idx       <= 2'd0;
                        busy      <= 1'b1;
                        // First write goes out in the very next cycle, so it
                        // takes its data straight from the config input.
                        bus.valid <= 1'b1;
                        bus.wr_en <= 1'b1;
                        bus.addr  <= reg_addr(2'd0);
                        bus.wdata <= cfg_intr;
                        state     <= WRITE;
                    end
                end

                WRITE: begin
                    if (idx == 2'd3) begin
                        if (verify) begin
                            idx       <= 2'd0;
                            bus.valid <= 1'b1;
                            bus.addr  <= reg_addr(2'd0);
                            state     <= RD_REQ;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        idx       <= idx + 2'd1;
                        bus.valid <= 1'b1;
                        bus.wr_en <= 1'b1;
                        bus.addr  <= reg_addr(idx + 2'd1);
                        bus.wdata <= shadow[idx + 2'd1];
                    end
                end

                RD_REQ: begin
                    lat_cnt <= 3'd1;
                    state   <= RD_WAIT;
                end

                RD_WAIT: begin
                    if (lat_cnt == 3'(RD_LAT)) begin
                        if (bus.rdata != shadow[idx]) begin
                            err_mask[idx] <= 1'b1;
                            err           <= 1'b1;
                        end
                        if (idx == 2'd3) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx       <= idx + 2'd1;
                            bus.valid <= 1'b1;
                            bus.addr  <= reg_addr(idx + 2'd1);
                            state     <= RD_REQ;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_reg_master.sv
// Directed bench for dma_reg_master: a RD_LAT=1 and a RD_LAT=3 instance, each
// with a small register responder, checked cycle by cycle against a timing model.
module tb_dma_reg_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start1 = 1'b0;
    logic        start3 = 1'b0;
    logic        verify_en = 1'b0;
    logic [31:0] cfg_v [4];
    logic        corrupt = 1'b0;

    logic        busy1, done1, err1;
    logic [3:0]  mask1;
    logic        busy3, done3, err3;
    logic [3:0]  mask3;

    logic [31:0] mem1 [4];
    logic [31:0] mem3 [4];
    logic [31:0] rdata1 = '0;
    logic [31:0] pipe3 [3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dma_reg_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
    dma_reg_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

    dma_reg_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h400), .RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .verify_en(verify_en),
        .cfg_intr(cfg_v[0]), .cfg_control(cfg_v[1]), .cfg_io_addr(cfg_v[2]), .cfg_mem_addr(cfg_v[3]),
        .bus(bus1.master), .busy(busy1), .done(done1), .err(err1), .err_mask(mask1)
    );

    dma_reg_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h400), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .verify_en(verify_en),
        .cfg_intr(cfg_v[0]), .cfg_control(cfg_v[1]), .cfg_io_addr(cfg_v[2]), .cfg_mem_addr(cfg_v[3]),
        .bus(bus3.master), .busy(busy3), .done(done3), .err(err3), .err_mask(mask3)
    );

    // One-cycle responder; optionally corrupts the read of 0x404.
    always @(posedge clk) begin
        if (bus1.valid && bus1.wr_en) mem1[bus1.addr[3:2]] <= bus1.wdata;
        if (bus1.valid && !bus1.wr_en)
            rdata1 <= (corrupt && bus1.addr == 32'h404) ? 32'hDEAD_BEEF : mem1[bus1.addr[3:2]];
    end
    assign bus1.rdata = rdata1;

    // Three-cycle responder: read data emerges from the end of a 3-deep pipe.
    always @(posedge clk) begin
        if (bus3.valid && bus3.wr_en) mem3[bus3.addr[3:2]] <= bus3.wdata;
        pipe3[0] <= (bus3.valid && !bus3.wr_en) ? mem3[bus3.addr[3:2]] : 32'h0;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign bus3.rdata = pipe3[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected bus/status for cycle k after the start edge, from the timing rules.
    task automatic check_cyc(input string who, input int k, input bit ve, input int lat, input int abort_at,
                             input logic v, input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic b, input logic dn);
        int len;
        int j;
        logic e_v, e_w, e_b, e_dn;
        logic [31:0] e_a, e_d;
        len = ve ? 4 + 4 * (1 + lat) + 1 : 5;
        e_v = 0; e_w = 0; e_b = 0; e_dn = 0; e_a = '0; e_d = '0;
        if (abort_at > 0 && k > abort_at) begin
            e_v = 0;
        end else if (k <= 4) begin
            e_v = 1; e_w = 1; e_b = 1;
            e_a = 32'h400 + 32'(4 * (k - 1));
            e_d = cfg_v[k-1];
        end else if (k < len) begin
            e_b = 1;
            j = k - 5;
            if (j % (1 + lat) == 0) begin
                e_v = 1;
                e_a = 32'h400 + 32'(4 * (j / (1 + lat)));
            end
        end else if (k == len) begin
            e_b = 1; e_dn = 1;
        end
        check($sformatf("%s c%0d valid", who, k), {31'b0, v}, {31'b0, e_v});
        check($sformatf("%s c%0d busy", who, k), {31'b0, b}, {31'b0, e_b});
        check($sformatf("%s c%0d done", who, k), {31'b0, dn}, {31'b0, e_dn});
        if (e_v) begin
            check($sformatf("%s c%0d wr_en", who, k), {31'b0, w}, {31'b0, e_w});
            check($sformatf("%s c%0d addr", who, k), a, e_a);
            if (e_w) check($sformatf("%s c%0d wdata", who, k), d, e_d);
        end
    endtask

    // Start one sequence and check every cycle until two cycles past done.
    task automatic run_seq(input string who, input bit use3, input bit ve, input bit reassert,
                           input int abort_at, input logic [3:0] exp_mask);
        int lat;
        int len;
        lat = use3 ? 3 : 1;
        len = ve ? 4 + 4 * (1 + lat) + 1 : 5;
        verify_en = ve;
        @(negedge clk);
        if (use3) start3 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start3 = 1'b0;
        for (int k = 1; k <= len + 2; k++) begin
            if (use3)
                check_cyc(who, k, ve, lat, abort_at, bus3.valid, bus3.wr_en, bus3.addr, bus3.wdata, busy3, done3);
            else
                check_cyc(who, k, ve, lat, abort_at, bus1.valid, bus1.wr_en, bus1.addr, bus1.wdata, busy1, done1);
            start1 = reassert && (k == 2 || k == 7);
            if (abort_at > 0 && k == abort_at) reset = 1'b1;
            if (abort_at > 0 && k == abort_at + 1) reset = 1'b0;
            @(negedge clk);
        end
        start1 = 1'b0;
        if (use3) begin
            check({who, " err_mask"}, {28'b0, mask3}, {28'b0, exp_mask});
            check({who, " err"}, {31'b0, err3}, {31'b0, |exp_mask});
        end else begin
            check({who, " err_mask"}, {28'b0, mask1}, {28'b0, exp_mask});
            check({who, " err"}, {31'b0, err1}, {31'b0, |exp_mask});
        end
    endtask

    initial begin
        cfg_v[0] = 32'h0000_0001;
        cfg_v[1] = 32'hA5A5_0003;
        cfg_v[2] = 32'h1000_0000;
        cfg_v[3] = 32'h2000_0040;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst valid", {31'b0, bus1.valid}, 32'h0);
        check("rst wr_en", {31'b0, bus1.wr_en}, 32'h0);
        check("rst addr", bus1.addr, 32'h0);
        check("rst wdata", bus1.wdata, 32'h0);
        check("rst busy", {31'b0, busy1}, 32'h0);
        check("rst done", {31'b0, done1}, 32'h0);
        check("rst err", {31'b0, err1}, 32'h0);
        check("rst err_mask", {28'b0, mask1}, 32'h0);
        reset = 1'b0;

        run_seq("verify_ok", 1'b0, 1'b1, 1'b0, 0, 4'b0000);

        corrupt = 1'b1;
        run_seq("verify_bad", 1'b0, 1'b1, 1'b0, 0, 4'b0010);
        corrupt = 1'b0;
        run_seq("verify_clear", 1'b0, 1'b1, 1'b0, 0, 4'b0000);

        cfg_v[0] = 32'hFFFF_FFFF;
        cfg_v[1] = 32'h0000_0000;
        cfg_v[2] = 32'h1234_5678;
        cfg_v[3] = 32'h8765_4321;
        run_seq("write_only", 1'b0, 1'b0, 1'b0, 0, 4'b0000);

        run_seq("restart_ignored", 1'b0, 1'b1, 1'b1, 0, 4'b0000);

        corrupt = 1'b1;
        run_seq("abort", 1'b0, 1'b1, 1'b0, 6, 4'b0000);
        corrupt = 1'b0;
        run_seq("after_abort", 1'b0, 1'b1, 1'b0, 0, 4'b0000);

        cfg_v[0] = 32'h0000_0001;
        cfg_v[1] = 32'hA5A5_0003;
        cfg_v[2] = 32'h1000_0000;
        cfg_v[3] = 32'h2000_0040;
        run_seq("lat3", 1'b1, 1'b1, 1'b0, 0, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
